// File: rtl/button_event_arbiter_pkg.sv
// Shared types and parameter checks for the button event arbiter.
package button_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } arbState_e;

    localparam int unsigned MinButtons = 2;
    localparam int unsigned MaxButtons = 16;

    function automatic bit paramsLegal(input int unsigned numButtons, input int unsigned idWidth);
        return (numButtons >= MinButtons) && (numButtons <= MaxButtons) &&
               (idWidth == $clog2(numButtons));
    endfunction

endpackage

// File: rtl/button_event_arbiter_if.sv
// Press-pulse inputs and event handshake between debouncers, arbiter and consumer.
interface button_event_arbiter_if #(
    parameter int unsigned NumButtons = 4,
    parameter int unsigned IdWidth    = 2
);
    logic [NumButtons-1:0] ButtonPulse;
    logic                  EventReady;
    logic                  OverrunClear;
    logic                  EventValid;
    logic [IdWidth-1:0]    EventId;
    logic [NumButtons-1:0] PendingMask;
    logic [NumButtons-1:0] Overrun;

    modport master (
        input  ButtonPulse, EventReady, OverrunClear,
        output EventValid, EventId, PendingMask, Overrun
    );

    modport slave (
        output ButtonPulse, EventReady, OverrunClear,
        input  EventValid, EventId, PendingMask, Overrun
    );
endinterface

// File: rtl/button_event_arbiter_round_robin_picker.sv
// Combinational round-robin select: lowest set Mask bit at or above Pointer, wrapping to 0.
module round_robin_picker #(
    parameter int unsigned NumButtons = 4,
    parameter int unsigned IdWidth    = 2
) (
    input  logic [NumButtons-1:0] Mask,
    input  logic [IdWidth-1:0]    Pointer,
    output logic                  Any,
    output logic [IdWidth-1:0]    Index
);

    logic [IdWidth-1:0] candidate;

    // Scan offsets from farthest to nearest so the nearest hit is the last write.
    always_comb begin
        Any       = 1'b0;
        Index     = '0;
        candidate = '0;
        for (int unsigned k = NumButtons; k > 0; k--) begin
            candidate = IdWidth'((32'(Pointer) + k - 1) % NumButtons);
            if (Mask[candidate]) begin
                Any   = 1'b1;
                Index = candidate;
            end
        end
    end

endmodule

// File: rtl/button_event_arbiter.sv
// Latches per-channel press pulses and serialises them round-robin onto one valid/ready event port.
module button_event_arbiter
    import button_pkg::*;
#(
    parameter int unsigned NumButtons = 4,
    parameter int unsigned IdWidth    = 2
) (
    input  logic                   Clk,
    input  logic                   Reset,
    button_event_arbiter_if.master bus
);

    if (!paramsLegal(NumButtons, IdWidth)) begin : gBadParams
        $error("button_event_arbiter: NumButtons must be 2..16 and IdWidth must equal clog2(NumButtons)");
    end

    localparam logic [IdWidth-1:0] LastIdx = IdWidth'(NumButtons - 1);

    arbState_e             state;
    logic [IdWidth-1:0]    pointer;
    logic [IdWidth-1:0]    eventId;
    logic                  eventValid;
    logic [NumButtons-1:0] pending;
    logic [NumButtons-1:0] overrun;

    logic                  pickAny;
    logic [IdWidth-1:0]    pickIdx;
    logic                  accept;
    logic [NumButtons-1:0] acceptMask;
    logic [NumButtons-1:0] overrunHit;

    round_robin_picker #(
        .NumButtons(NumButtons),
        .IdWidth   (IdWidth)
    ) picker (
        .Mask   (pending),
        .Pointer(pointer),
        .Any    (pickAny),
        .Index  (pickIdx)
    );

    // A pulse on the channel being accepted re-arms it instead of counting as overrun.
    always_comb begin
        accept     = (state == ST_OFFER) && bus.EventReady;
        acceptMask = '0;
        if (accept) begin
            acceptMask[eventId] = 1'b1;
        end
        overrunHit = bus.ButtonPulse & pending & ~acceptMask;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= ST_IDLE;
            pointer    <= '0;
            eventId    <= '0;
            eventValid <= 1'b0;
            pending    <= '0;
            overrun    <= '0;
        end else begin
            pending <= (pending & ~acceptMask) | bus.ButtonPulse;
            overrun <= (bus.OverrunClear ? '0 : overrun) | overrunHit;
            case (state)
                ST_IDLE: begin
                    if (pickAny) begin
                        eventId    <= pickIdx;
                        eventValid <= 1'b1;
                        state      <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (bus.EventReady) begin
                        pointer    <= (eventId == LastIdx) ? '0 : eventId + 1'b1;
                        eventValid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.EventValid  = eventValid;
    assign bus.EventId     = eventId;
    assign bus.PendingMask = pending;
    assign bus.Overrun     = overrun;

endmodule

// File: doc/button_event_arbiter.md
# button_event_arbiter

Collects single-cycle press pulses from up to NumButtons debouncer channels and serializes them onto one event output with a valid/ready handshake. Presses are latched per channel until consumed, and a round-robin pointer shares the single consumer fairly between channels. It sits between the bank of button debouncers and the control logic that consumes press events, such as a menu FSM or a counter controller. Overflow is reported per channel as sticky flags.

## Interface
- NumButtons, 4, number of button channels; legal range 2..16.
- IdWidth, 2, width of EventId; must equal clog2(NumButtons).
- Clk  input  1  single system clock; all logic is rising-edge.
- Reset  input  1  synchronous, active-high; sampled on the Clk rising edge.
- ButtonPulse  input  NumButtons  debounced press pulses, synchronous to Clk; each cycle a bit is high counts as one press.
- EventReady  input  1  consumer can accept the offered event.
- OverrunClear  input  1  clears all Overrun bits.
- EventValid  output  1  an event is offered on EventId.
- EventId  output  IdWidth  index of the channel being offered.
- PendingMask  output  NumButtons  latched, not-yet-consumed presses.
- Overrun  output  NumButtons  sticky flags; a press arrived while that channel was already pending.

## Operation
- Reset, state: state=IDLE, Pointer=0.
- Reset, outputs: EventValid=0, EventId=0, PendingMask=0, Overrun=0.
- Pending set: if ButtonPulse[i]=1, Pending[i] becomes 1 next cycle.
- Overrun set: if ButtonPulse[i]=1 while Pending[i] is already 1 and channel i is not being accepted this cycle:
  - Overrun[i] becomes 1.
  - Pending[i] stays 1, so the two presses coalesce into one event.
- FSM states are IDLE and OFFER.
- IDLE with PendingMask=0: remain in IDLE; EventValid=0.
- IDLE with PendingMask≠0:
  - Select the lowest pending index at or above Pointer, wrapping to index 0.
  - Register the selected index into EventId, set EventValid=1, go to OFFER.
- OFFER:
  - EventId and EventValid stay stable until EventValid&EventReady.
  - New pulses on other channels do not change the offer.
- Accept (OFFER with EventReady=1), all in the same edge:
  - Pending[EventId] is cleared.
  - Pointer becomes EventId+1, wrapping from NumButtons-1 to 0 (applies to non-power-of-two NumButtons too).
  - EventValid becomes 0 and the FSM goes to IDLE.
- Pulse on channel EventId in the accepting cycle:
  - Pending[EventId] stays 1 (the set overrides the clear).
  - Overrun is not set.
- Pulse on channel EventId during OFFER without accept: Overrun[EventId] is set.
- OverrunClear clears all Overrun bits. If a new overrun occurs in the same cycle, that bit ends up 1 (set overrides clear).
- Reset during OFFER: the offered event and all pending presses are discarded.

## Timing
- ButtonPulse[i] high at edge t: PendingMask[i]=1 after edge t, EventValid=1 after edge t+1.
- Minimum press-to-valid latency is 2 cycles.
- Throughput is at most 1 event per 2 cycles (IDLE and OFFER alternate), which is ample for debounced buttons.
- All outputs are registered; there is no combinational path from EventReady to EventValid or EventId.
- Overrun[i] rises on the edge after the offending pulse.

## Structure
- Package button_pkg holds:
  - state encodings ST_IDLE=1'b0 and ST_OFFER=1'b1;
  - the NumButtons legality check, 2..16 with IdWidth==clog2(NumButtons), as an elaboration-time error.
- Sub-module round_robin_picker:
  - purely combinational;
  - inputs: Mask[NumButtons], Pointer[IdWidth];
  - outputs: Any, Index[IdWidth].
- The arbiter top holds the Pending and Overrun registers, the Pointer register, the FSM, and the output registers.

## Test plan
- Reset release, no pulses for 20 cycles -> EventValid=0, PendingMask=0, Overrun=0 throughout.
- Single pulse on channel 2, EventReady=1:
  - PendingMask=4'b0100 one cycle later;
  - EventValid=1 with EventId=2 the next cycle;
  - after acceptance PendingMask=0 and Pointer=3.
- Pulses on channels 0, 1 and 3 in the same cycle, Pointer=0, EventReady=1:
  - grant order 0, 1, 3, one event every 2 cycles;
  - no Overrun.
- Channel 1 pending with EventReady=0, second pulse on channel 1:
  - Overrun=4'b0010;
  - only one event with EventId=1 is delivered;
  - OverrunClear pulse returns Overrun to 0.
- NumButtons=3, pending channels 2 and 0, Pointer=2 -> grant order 2 then 0, with Pointer wrapping 2 -> 0 -> 1.
- Reset asserted while in OFFER with PendingMask=4'b1010 -> next cycle EventValid=0, PendingMask=0, Pointer=0.
- Pulse on the offered channel in the accepting cycle -> Pending for that channel stays 1 and is re-offered; Overrun stays 0.
